grn_attractor_ctrl: RTL and testbench

- Downstream consumer and sequencer for the per-node two-stream update cells of a Boolean gene-regulatory-network accelerator.
- Collects the N node outputs into state vectors s0 and s1, and drives the shared reset_nos, init_state, start_s0 and start_s1 controls.
- Uses Floyd cycle detection to find the attractor reached from a given initial state: s0 is the tortoise (its cells advance every 2nd start_s0 pulse), s1 is the hare (advances every start_s1 pulse).
- Reports the attractor state and period to the result writer.

---
 rtl/grn_attractor_ctrl_if.sv | 32 +++
 rtl/grn_attractor_ctrl.sv | 166 ++++++++++++++++
 tb/tb_grn_attractor_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grn_attractor_ctrl_if.sv
// Handshake and state-vector bundle between the attractor controller, the node cells and the result writer.
// Signal prefixes are from the controller's point of view.
interface grn_attractor_ctrl_if #(
    parameter int N_NODES = 8,
    parameter int CNT_W   = 16
);
    logic               i_start;
    logic [N_NODES-1:0] i_init_val;
    logic [N_NODES-1:0] i_s0;
    logic [N_NODES-1:0] i_s1;
    logic               o_reset_nos;
    logic [N_NODES-1:0] o_init_state;
    logic               o_start_s0;
    logic               o_start_s1;
    logic               o_busy;
    logic               o_done;
    logic [N_NODES-1:0] o_attractor;
    logic [CNT_W-1:0]   o_period;
    logic               o_timeout;

    modport slave (
        input  i_start, i_init_val, i_s0, i_s1,
        output o_reset_nos, o_init_state, o_start_s0, o_start_s1,
               o_busy, o_done, o_attractor, o_period, o_timeout
    );

    modport master (
        output i_start, i_init_val, i_s0, i_s1,
        input  o_reset_nos, o_init_state, o_start_s0, o_start_s1,
               o_busy, o_done, o_attractor, o_period, o_timeout
    );
endinterface

// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sequencer for the two-stream GRN node cells: s0 is the tortoise, s1 the hare.
// Optional hare step limit with timeout reporting is enabled by defining GRN_TIMEOUT_EN.
module grn_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic                clk,
    input  logic                rst,
    grn_attractor_ctrl_if.slave io_ctrl
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PERIOD,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_p;
    logic [CNT_W-1:0]   r_period;
    logic [N_NODES-1:0] r_init_state;
    logic [N_NODES-1:0] r_attractor;
    logic               w_match;
    logic               w_loop;
    logic               w_limit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The tortoise has taken exactly h/2 steps only when h is even.
    assign w_match = (r_state == ST_RUN) && !r_h[0] && (r_h > CNT_W'(1)) &&
                     (io_ctrl.i_s0 == io_ctrl.i_s1);
    assign w_loop  = (r_state == ST_PERIOD) && (r_p != '0) &&
                     (io_ctrl.i_s1 == r_attractor);

`ifdef GRN_TIMEOUT_EN
    logic r_timeout;

    assign w_limit = ((r_state == ST_RUN) || (r_state == ST_PERIOD)) &&
                     (r_h >= CNT_W'(MAX_STEPS)) && !w_loop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_IDLE) && io_ctrl.i_start) begin
            r_timeout <= 1'b0;
        end else if (w_limit) begin
            r_timeout <= 1'b1;
        end
    end

    assign io_ctrl.o_timeout = r_timeout;
`else
    assign w_limit           = 1'b0;
    assign io_ctrl.o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        io_ctrl.o_reset_nos = 1'b0;
        io_ctrl.o_start_s0  = 1'b0;
        io_ctrl.o_start_s1  = 1'b0;
        io_ctrl.o_busy      = 1'b0;
        io_ctrl.o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_ctrl.i_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                io_ctrl.o_reset_nos = 1'b1;
                io_ctrl.o_busy      = 1'b1;
                w_state_nxt         = ST_RUN;
            end
            ST_RUN: begin
                io_ctrl.o_start_s0 = 1'b1;
                io_ctrl.o_start_s1 = 1'b1;
                io_ctrl.o_busy     = 1'b1;
                if (w_limit) begin
                    w_state_nxt = ST_DONE;
                end else if (w_match) begin
                    w_state_nxt = ST_PERIOD;
                end
            end
            ST_PERIOD: begin
                io_ctrl.o_start_s1 = 1'b1;
                io_ctrl.o_busy     = 1'b1;
                if (w_loop || w_limit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                io_ctrl.o_done = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h          <= '0;
            r_p          <= '0;
            r_period     <= '0;
            r_init_state <= '0;
            r_attractor  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_ctrl.i_start) begin
                        r_init_state <= io_ctrl.i_init_val;
                        r_attractor  <= '0;
                        r_period     <= '0;
                    end
                end
                ST_LOAD: begin
                    r_h <= '0;
                    r_p <= '0;
                end
                ST_RUN: begin
                    r_h <= sat_inc(r_h);
                    if (w_limit) begin
                        r_attractor <= io_ctrl.i_s1;
                        r_period    <= '0;
                    end else if (w_match) begin
                        r_attractor <= io_ctrl.i_s1;
                        // The hare step issued on the match cycle is already in flight.
                        r_p         <= CNT_W'(1);
                    end
                end
                ST_PERIOD: begin
                    r_h <= sat_inc(r_h);
                    r_p <= sat_inc(r_p);
                    if (w_loop) begin
                        r_period <= r_p;
                    end else if (w_limit) begin
                        r_attractor <= io_ctrl.i_s1;
                        r_period    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_ctrl.o_init_state = r_init_state;
    assign io_ctrl.o_attractor  = r_attractor;
    assign io_ctrl.o_period     = r_period;
endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: node cells modelled by a lookup-table map, results checked against
// a direct Floyd tortoise/hare evaluation of the same map.
`timescale 1ns/1ps
module tb_grn_attractor_ctrl;
    localparam int N  = 8;
    localparam int CW = 16;
`ifdef GRN_TIMEOUT_EN
    localparam int MAXS = 10;
    localparam bit TMO  = 1'b1;
`else
    localparam int MAXS = 65535;
    localparam bit TMO  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grn_attractor_ctrl_if #(.N_NODES(N), .CNT_W(CW)) bus();

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_ctrl (bus)
    );

    logic [7:0] lut [256];
    logic [7:0] r_tort;
    logic [7:0] r_hare;
    logic       r_pass;
    int         n_checks = 0;
    int         n_fail   = 0;

    // Node cells: hare steps on every start_s1, tortoise on every second start_s0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tort <= '0;
            r_hare <= '0;
            r_pass <= 1'b0;
        end else if (bus.o_reset_nos) begin
            r_tort <= bus.o_init_state;
            r_hare <= bus.o_init_state;
            r_pass <= 1'b0;
        end else begin
            if (bus.o_start_s1) r_hare <= lut[r_hare];
            if (bus.o_start_s0) begin
                r_pass <= ~r_pass;
                if (r_pass) r_tort <= lut[r_tort];
            end
        end
    end
    assign bus.i_s0 = r_tort;
    assign bus.i_s1 = r_hare;

    task automatic set_mode(input int m);
        for (int i = 0; i < 256; i++) begin
            case (m)
                0: lut[i] = 8'(i);
                1: lut[i] = 8'((i + 1) % 4);
                2: lut[i] = (i == 0) ? 8'd1 : (i == 1) ? 8'd2 : (i == 2) ? 8'd3 :
                            (i == 3) ? 8'd4 : 8'd2;
                3: lut[i] = 8'((i + 1) % 256);
                default: lut[i] = 8'($urandom_range(0, 63));
            endcase
        end
    endtask

    // Floyd on the map itself: tortoise one step, hare two steps per round.
    function automatic void ref_eval(input logic [7:0] init, output int lat,
                                     output logic [7:0] att, output int per, output bit to);
        logic [7:0] t, h, x;
        int k, hd;
        t = init; h = init; k = 0;
        do begin
            t = lut[t];
            h = lut[lut[h]];
            k++;
        end while (t != h && k < 1000);
        hd  = 2 * k;
        att = h;
        per = 1;
        x   = lut[att];
        while (x != att && per < 1000) begin
            x = lut[x];
            per++;
        end
        to  = 1'b0;
        lat = 3 + hd + per;
        if (TMO && (MAXS < hd + per)) begin
            to  = 1'b1;
            per = 0;
            x   = init;
            for (int i = 0; i < MAXS; i++) x = lut[x];
            att = x;
            lat = 3 + MAXS;
        end
    endfunction

    task automatic run_case(input string tag, input logic [7:0] init);
        int lat, per, cnt, busy_drop;
        logic [7:0] att;
        bit to;
        ref_eval(init, lat, att, per, to);
        @(negedge clk);
        bus.i_init_val = init;
        bus.i_start    = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cnt = 1;
        busy_drop = 0;
        n_checks++;
        if (bus.o_reset_nos !== 1'b1 || bus.o_init_state !== init) begin
            n_fail++;
            $display("FAIL %s load: reset_nos=%0b init_state=%0h, expected 1/%0h",
                     tag, bus.o_reset_nos, bus.o_init_state, init);
        end
        while (bus.o_done !== 1'b1 && cnt < lat + 40) begin
            if (bus.o_busy !== 1'b1) busy_drop++;
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cnt, lat);
        end
        n_checks++;
        if (bus.o_attractor !== att) begin
            n_fail++;
            $display("FAIL %s attractor: got %0h, expected %0h", tag, bus.o_attractor, att);
        end
        n_checks++;
        if (bus.o_period !== 16'(per)) begin
            n_fail++;
            $display("FAIL %s period: got %0d, expected %0d", tag, bus.o_period, per);
        end
        n_checks++;
        if (bus.o_timeout !== to) begin
            n_fail++;
            $display("FAIL %s timeout: got %0b, expected %0b", tag, bus.o_timeout, to);
        end
        n_checks++;
        if (busy_drop !== 0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: %0d low cycles while running, busy at done=%0b, expected 0/0",
                     tag, busy_drop, bus.o_busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_attractor !== att) begin
            n_fail++;
            $display("FAIL %s after done: done=%0b busy=%0b attractor=%0h, expected 0/0/%0h",
                     tag, bus.o_done, bus.o_busy, bus.o_attractor, att);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_init_val = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.o_reset_nos, bus.o_start_s0, bus.o_start_s1, bus.o_busy, bus.o_done,
             bus.o_timeout, bus.o_init_state, bus.o_attractor, bus.o_period} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs not all zero (busy=%0b attractor=%0h period=%0d)",
                     bus.o_busy, bus.o_attractor, bus.o_period);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.o_reset_nos, bus.o_start_s0, bus.o_start_s1, bus.o_busy, bus.o_done,
             bus.o_timeout, bus.o_init_state, bus.o_attractor, bus.o_period} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs not all zero (busy=%0b start_s1=%0b), expected 0",
                     bus.o_busy, bus.o_start_s1);
        end
    endtask

    task automatic test_identity();
        set_mode(0);
        run_case("identity", 8'h02);
    endtask

    task automatic test_ring4();
        set_mode(1);
        run_case("ring4", 8'h00);
    endtask

    task automatic test_transient();
        set_mode(2);
        run_case("transient", 8'h00);
    endtask

    task automatic test_handshake();
        int lat, per, cnt, ndone, first, late_busy;
        logic [7:0] att;
        bit to;
        set_mode(1);
        ref_eval(8'h01, lat, att, per, to);
        @(negedge clk);
        bus.i_init_val = 8'h01;
        bus.i_start    = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cnt = 1;
        n_checks++;
        if (bus.o_reset_nos !== 1'b1 || bus.o_init_state !== 8'h01 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_load: reset_nos=%0b init_state=%0h busy=%0b, expected 1/01/1",
                     bus.o_reset_nos, bus.o_init_state, bus.o_busy);
        end
        @(negedge clk);
        cnt = 2;
        n_checks++;
        if (bus.o_reset_nos !== 1'b0 || bus.o_start_s0 !== 1'b1 || bus.o_start_s1 !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_run: reset_nos=%0b start_s0=%0b start_s1=%0b, expected 0/1/1",
                     bus.o_reset_nos, bus.o_start_s0, bus.o_start_s1);
        end
        bus.i_init_val = 8'hAA;
        bus.i_start    = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cnt = 3;
        ndone = 0;
        first = 0;
        late_busy = 0;
        while (cnt < lat + 20) begin
            if (bus.o_done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first = cnt;
                    bus.i_start = 1'b1;
                end
            end else begin
                bus.i_start = 1'b0;
            end
            if (first != 0 && cnt > first && (bus.o_busy === 1'b1 || bus.o_reset_nos === 1'b1))
                late_busy++;
            @(negedge clk);
            cnt++;
        end
        bus.i_start = 1'b0;
        n_checks++;
        if (ndone !== 1 || first !== lat) begin
            n_fail++;
            $display("FAIL hs_single_done: %0d done pulses first at %0d, expected 1 at %0d",
                     ndone, first, lat);
        end
        n_checks++;
        if (late_busy !== 0 || bus.o_init_state !== 8'h01) begin
            n_fail++;
            $display("FAIL hs_ignored_start: %0d busy cycles after done, init_state=%0h, expected 0/01",
                     late_busy, bus.o_init_state);
        end
    endtask

    task automatic test_rst_mid();
        int cnt;
        set_mode(2);
        @(negedge clk);
        bus.i_init_val = 8'h00;
        bus.i_start    = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cnt = 1;
        while (cnt < 4) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (bus.o_start_s1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: start_s1=%0b, expected 1", bus.o_start_s1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_reset_nos, bus.o_start_s0, bus.o_start_s1, bus.o_busy, bus.o_done,
             bus.o_timeout, bus.o_attractor, bus.o_period} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%0b start_s1=%0b attractor=%0h period=%0d, expected all 0",
                     bus.o_busy, bus.o_start_s1, bus.o_attractor, bus.o_period);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: busy=%0b done=%0b, expected 0/0", bus.o_busy, bus.o_done);
        end
        run_case("after_rst", 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            set_mode(4);
            run_case($sformatf("random%0d", i), 8'($urandom_range(0, 63)));
        end
    endtask

    task automatic test_timeout();
        set_mode(3);
        run_case("count256", 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_ring4();
        test_transient();
        test_handshake();
        test_rst_mid();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
